load_store_unit: RTL

- Sits between the multicycle datapath's ALU-out and B registers and the 64-bit data memory; its LoadData output feeds the memory-data register.
- Provides RV64 sub-doubleword access: lb/lh/lw/ld/lbu/lhu/lwu with sign or zero extension, and sb/sh/sw/sd.
- The memory only reads and writes whole aligned doublewords, so sb/sh/sw run as a read-modify-write sequence.
- The control unit issues Req and stalls on Busy until Done.

---
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Control-unit and memory-side signals of the load/store unit.
// slave is the unit itself; master is the control unit plus the doubleword memory.
interface load_store_unit_if;
  logic        Req;
  logic        Wr;
  logic [2:0]  Funct3;
  logic [63:0] Address;
  logic [63:0] StoreData;
  logic [63:0] LoadData;
  logic        Done;
  logic        Busy;
  logic        Fault;
  logic [63:0] MemAddress;
  logic [63:0] MemDataOut;
  logic        MemWr;
  logic [63:0] MemDataIn;

  modport master (
    output Req, Wr, Funct3, Address, StoreData, MemDataIn,
    input  LoadData, Done, Busy, Fault, MemAddress, MemDataOut, MemWr
  );

  modport slave (
    input  Req, Wr, Funct3, Address, StoreData, MemDataIn,
    output LoadData, Done, Busy, Fault, MemAddress, MemDataOut, MemWr
  );
endinterface

// File: rtl/load_store_unit.sv
// RV64 sub-doubleword load/store over an aligned 64-bit memory; sb/sh/sw do read-modify-write.
// Done after L+1 (load), L+2 (sb/sh/sw), 2 (sd), 1 (fault) cycles; Req is ignored while Busy.
module load_store_unit #(
  parameter int MEM_READ_LATENCY = 1
) (
  input logic               Clk,
  input logic               Reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_READ_LATENCY);

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] store_q, store_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] load_data_q, load_data_d;
  logic [63:0] mem_data_out_q, mem_data_out_d;
  logic        fault_q, fault_d;

  logic        req_illegal;
  logic        req_misalign;
  logic        req_fault;
  logic [5:0]  lane_shift;
  logic [63:0] lane_mask;
  logic [63:0] ins_mask;
  logic [63:0] merged;
  logic [63:0] field;
  logic [63:0] extracted;

  // Legality of the incoming request, evaluated on the raw inputs at accept time.
  always_comb begin
    req_illegal  = bus.Wr ? bus.Funct3[2] : (bus.Funct3 == 3'b111);
    req_misalign = 1'b0;
    case (bus.Funct3[1:0])
      2'b01:   req_misalign = bus.Address[0];
      2'b10:   req_misalign = |bus.Address[1:0];
      2'b11:   req_misalign = |bus.Address[2:0];
      default: req_misalign = 1'b0;
    endcase
    req_fault = req_illegal | req_misalign;
  end

  always_comb begin
    lane_shift = {addr_q[2:0], 3'b000};
    lane_mask  = '1;
    case (funct3_q[1:0])
      2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
      2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = '1;
    endcase
    ins_mask = lane_mask << lane_shift;
    merged   = (bus.MemDataIn & ~ins_mask) | ((store_q << lane_shift) & ins_mask);
    field    = bus.MemDataIn >> lane_shift;
    case (funct3_q)
      3'b000:  extracted = {{56{field[7]}}, field[7:0]};
      3'b001:  extracted = {{48{field[15]}}, field[15:0]};
      3'b010:  extracted = {{32{field[31]}}, field[31:0]};
      3'b100:  extracted = {56'd0, field[7:0]};
      3'b101:  extracted = {48'd0, field[15:0]};
      3'b110:  extracted = {32'd0, field[31:0]};
      default: extracted = field;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wr_d           = wr_q;
    funct3_d       = funct3_q;
    store_d        = store_q;
    cnt_d          = cnt_q;
    load_data_d    = load_data_q;
    mem_data_out_d = mem_data_out_q;
    fault_d        = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Req) begin
          addr_d   = bus.Address;
          wr_d     = bus.Wr;
          funct3_d = bus.Funct3;
          store_d  = bus.StoreData;
          cnt_d    = CNT_INIT;
          fault_d  = req_fault;
          if (req_fault) begin
            state_d = S_DONE;
          end else if (bus.Wr && bus.Funct3[1:0] == 2'b11) begin
            // Full doubleword store needs no read phase.
            mem_data_out_d = bus.StoreData;
            state_d        = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (wr_q) begin
            mem_data_out_d = merged;
            state_d        = S_WR;
          end else begin
            load_data_d = extracted;
            state_d     = S_DONE;
          end
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      wr_q           <= 1'b0;
      funct3_q       <= '0;
      store_q        <= '0;
      cnt_q          <= '0;
      load_data_q    <= '0;
      mem_data_out_q <= '0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wr_q           <= wr_d;
      funct3_q       <= funct3_d;
      store_q        <= store_d;
      cnt_q          <= cnt_d;
      load_data_q    <= load_data_d;
      mem_data_out_q <= mem_data_out_d;
      fault_q        <= fault_d;
    end
  end

  // Reset gates the strobe directly so a reset landing in WR never writes.
  assign bus.MemWr      = (state_q == S_WR) && !Reset;
  assign bus.MemAddress = {addr_q[63:3], 3'b000};
  assign bus.MemDataOut = mem_data_out_q;
  assign bus.LoadData   = load_data_q;
  assign bus.Done       = (state_q == S_DONE);
  assign bus.Busy       = (state_q != S_IDLE);
  assign bus.Fault      = (state_q == S_DONE) && fault_q;

endmodule
